// File: rtl/m_cache_refill_pkg.sv
// Shared definitions for the read-miss refill controller: line geometry,
// FSM state encodings and the line-alignment helper.

`ifndef DADDR_WIDTH
`define DADDR_WIDTH 32
`endif
`ifndef DADDR
`define DADDR [`DADDR_WIDTH-1:0]
`endif

package m_cache_refill_pkg;

  // Line geometry: four 32-bit words, 16 bytes per line.
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
  localparam int unsigned LINE_OFF_W = 4;

  // State encodings.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_MREQ    = 3'd2;
  localparam logic [2:0] S_FILL    = 3'd3;
  localparam logic [2:0] S_INSTALL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_LOOKUP  = S_LOOKUP,
    ST_MREQ    = S_MREQ,
    ST_FILL    = S_FILL,
    ST_INSTALL = S_INSTALL
  } refill_state_t;

  // Clear the byte offset so the address points at the start of its line.
  function automatic logic [`DADDR_WIDTH-1:0] line_align(input logic [`DADDR_WIDTH-1:0] a);
    return {a[`DADDR_WIDTH-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/m_cache_refill_line_buffer.sv
// Four-word line buffer collecting memory beats during a refill.
// Data carries no reset: whether the contents are meaningful is tracked by
// the refill FSM, which only installs after all four words were written.

module m_line_buffer
  import m_cache_refill_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [1:0]        i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [LINE_W-1:0] o_line
);

  logic [WORD_W-1:0] mem_r [LINE_WORDS];

  // Write the addressed word when the strobe is high.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_idx] <= i_wdata;
    end else begin
      mem_r[i_idx] <= mem_r[i_idx];
    end
  end

  // Present the words as one line, word k in bits [32k+31:32k].
  always_comb begin
    o_line = {mem_r[3], mem_r[2], mem_r[1], mem_r[0]};
  end

endmodule

// File: rtl/m_cache_refill.sv
// Read-miss refill controller in front of the data cache install port.
// A load that misses stalls the CPU, the 4-word line is fetched from memory,
// installed in a single cycle, and the held load then replays as a hit.
// Stores never allocate; they are only held off while a refill runs.

module m_cache_refill
  import m_cache_refill_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rd,
  input  logic                 i_we,
  input  logic `DADDR          i_addr,
  input  logic                 i_rhit,
  output logic                 o_stall,
  output logic                 o_ie,
  output logic `DADDR          o_iaddr,
  output logic [LINE_W-1:0]    o_idata,
  output logic                 o_mreq,
  output logic `DADDR          o_maddr,
  input  logic                 i_mack,
  input  logic                 i_mvalid,
  input  logic [WORD_W-1:0]    i_mdata,
  output logic [CNT_WIDTH-1:0] o_miss_cnt
);

  refill_state_t        state_r;
  logic `DADDR          addr_r;
  logic [1:0]           cnt_r;
  logic                 stall_r;
  logic                 ie_r;
  logic                 mreq_r;
  logic `DADDR          iaddr_r;
  logic `DADDR          maddr_r;
  logic [LINE_W-1:0]    idata_r;
  logic [CNT_WIDTH-1:0] miss_cnt_r;

  logic                 buf_we_s;
  logic [LINE_W-1:0]    line_s;
  logic [LINE_W-1:0]    next_line_s;
  logic                 stall_s;

  // Beats are only captured while a fill is in progress.
  always_comb begin
    buf_we_s = (state_r == ST_FILL) && i_mvalid;
  end

  m_line_buffer u_line_buffer (
    .i_clk   (i_clk),
    .i_we    (buf_we_s),
    .i_idx   (cnt_r),
    .i_wdata (i_mdata),
    .o_line  (line_s)
  );

  // Line as it will look after the current beat lands, so the install data
  // can be registered on the same edge that writes the final word.
  always_comb begin
    next_line_s = line_s;
    next_line_s[{cnt_r, 5'd0} +: WORD_W] = i_mdata;
  end

  // A miss must stall the CPU in the very cycle the hit flag comes back.
  always_comb begin
    if ((state_r == ST_LOOKUP) && !i_rhit) begin
      stall_s = 1'b1;
    end else begin
      stall_s = stall_r;
    end
  end

  // Refill FSM with registered stall, request and install outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= '0;
      cnt_r      <= 2'd0;
      stall_r    <= 1'b0;
      ie_r       <= 1'b0;
      mreq_r     <= 1'b0;
      iaddr_r    <= '0;
      maddr_r    <= '0;
      idata_r    <= '0;
      miss_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // Stores alone leave the controller idle.
          if (i_rd) begin
            addr_r  <= i_addr;
            state_r <= ST_LOOKUP;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOOKUP: begin
          if (i_rhit) begin
            // Back-to-back loads keep flowing through LOOKUP without bubbles.
            if (i_rd) begin
              addr_r  <= i_addr;
              state_r <= ST_LOOKUP;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            stall_r <= 1'b1;
            mreq_r  <= 1'b1;
            maddr_r <= line_align(addr_r);
            if (~&miss_cnt_r) begin
              miss_cnt_r <= miss_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
              miss_cnt_r <= miss_cnt_r;
            end
            state_r <= ST_MREQ;
          end
        end
        ST_MREQ: begin
          if (i_mack) begin
            mreq_r  <= 1'b0;
            cnt_r   <= 2'd0;
            state_r <= ST_FILL;
          end else begin
            state_r <= ST_MREQ;
          end
        end
        ST_FILL: begin
          // Gaps between beats are allowed for any length.
          if (i_mvalid) begin
            cnt_r <= cnt_r + 2'd1;
            if (cnt_r == 2'd3) begin
              ie_r    <= 1'b1;
              iaddr_r <= line_align(addr_r);
              idata_r <= next_line_s;
              state_r <= ST_INSTALL;
            end else begin
              state_r <= ST_FILL;
            end
          end else begin
            state_r <= ST_FILL;
          end
        end
        ST_INSTALL: begin
          // Single install cycle; stall releases so the load can replay.
          ie_r    <= 1'b0;
          stall_r <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          stall_r <= 1'b0;
          ie_r    <= 1'b0;
          mreq_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive the ports from their registers.
  always_comb begin
    o_stall    = stall_s;
    o_ie       = ie_r;
    o_mreq     = mreq_r;
    o_iaddr    = iaddr_r;
    o_maddr    = maddr_r;
    o_idata    = idata_r;
    o_miss_cnt = miss_cnt_r;
  end

endmodule

// File: tb/tb_m_cache_refill.sv
// Directed, table-driven bench for m_cache_refill plus hand-written
// sequences for store hold-off, reset abort and counter saturation.

module tb_m_cache_refill;

  logic          clk;
  logic          rst_n;
  logic          rd;
  logic          we;
  logic [31:0]   addr;
  logic          rhit;
  logic          mack;
  logic          mvalid;
  logic [31:0]   mdata;

  logic          o_stall, o_ie, o_mreq;
  logic [31:0]   o_iaddr, o_maddr;
  logic [127:0]  o_idata;
  logic [31:0]   o_miss_cnt;

  logic          s2_stall, s2_ie, s2_mreq;
  logic [31:0]   s2_iaddr, s2_maddr;
  logic [127:0]  s2_idata;
  logic [1:0]    s2_miss_cnt;

  int checks = 0;
  int errors = 0;

  m_cache_refill dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd(rd), .i_we(we), .i_addr(addr),
    .i_rhit(rhit), .o_stall(o_stall), .o_ie(o_ie), .o_iaddr(o_iaddr),
    .o_idata(o_idata), .o_mreq(o_mreq), .o_maddr(o_maddr), .i_mack(mack),
    .i_mvalid(mvalid), .i_mdata(mdata), .o_miss_cnt(o_miss_cnt)
  );

  m_cache_refill #(.CNT_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rd(rd), .i_we(we), .i_addr(addr),
    .i_rhit(rhit), .o_stall(s2_stall), .o_ie(s2_ie), .o_iaddr(s2_iaddr),
    .o_idata(s2_idata), .o_mreq(s2_mreq), .o_maddr(s2_maddr), .i_mack(mack),
    .i_mvalid(mvalid), .i_mdata(mdata), .o_miss_cnt(s2_miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rd;
    logic         we;
    logic [31:0]  addr;
    logic         rhit;
    logic         mack;
    logic         mv;
    logic [31:0]  mdata;
    logic         e_stall;
    logic         e_ie;
    logic         e_mreq;
    logic [31:0]  e_maddr;
    logic [31:0]  e_iaddr;
    logic [127:0] e_idata;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd = 1'b0; we = 1'b0; addr = 32'h0; rhit = 1'b0;
    mack = 1'b0; mvalid = 1'b0; mdata = 32'h0;
  endtask

  // Full miss on address a with beats d0..d0+3, mack on first MREQ cycle.
  task automatic run_miss(input logic [31:0] a, input logic [31:0] d0);
    logic seen;
    logic [127:0] line;
    line = {d0 + 32'd3, d0 + 32'd2, d0 + 32'd1, d0};
    @(negedge clk); idle_inputs(); rd = 1'b1; addr = a;
    #1 chk("miss_idle_stall", {127'd0, o_stall}, 128'd0);
    @(negedge clk); rhit = 1'b0;
    #1 chk("miss_lookup_stall", {127'd0, o_stall}, 128'd1);
    seen = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk); mack = 1'b0;
      #1;
      if (o_mreq) begin
        seen = 1'b1;
        break;
      end
    end
    chk("miss_mreq_seen", {127'd0, seen}, 128'd1);
    chk("miss_maddr", {96'd0, o_maddr}, {96'd0, a & 32'hFFFF_FFF0});
    mack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); mack = 1'b0; mvalid = 1'b1; mdata = d0 + k;
      #1 chk("miss_fill_noie", {126'd0, o_stall, o_ie}, {126'd0, 1'b1, 1'b0});
    end
    @(negedge clk); mvalid = 1'b0;
    #1;
    chk("miss_install_ie", {126'd0, o_stall, o_ie}, {126'd0, 1'b1, 1'b1});
    chk("miss_iaddr", {96'd0, o_iaddr}, {96'd0, a & 32'hFFFF_FFF0});
    chk("miss_idata", o_idata, line);
    @(negedge clk);
    #1 chk("miss_replay_idle", {126'd0, o_stall, o_ie}, 128'd0);
    @(negedge clk); rd = 1'b0; rhit = 1'b1;
    #1 chk("miss_replay_hit", {127'd0, o_stall}, 128'd0);
    @(negedge clk); idle_inputs();
  endtask

  localparam logic [127:0] LINE_A = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic accepted, prev_ie;
    int overlap, ie_cnt, stall_cyc, early_we;

    // Hit stream, miss with MREQ wait and beat gap, stray beats/acks.
    vt[0]  = '{1'b1,1'b0,32'h100, 1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[1]  = '{1'b1,1'b0,32'h104, 1'b1,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[2]  = '{1'b1,1'b0,32'h108, 1'b1,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[3]  = '{1'b0,1'b0,32'h0,   1'b1,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[4]  = '{1'b0,1'b0,32'h0,   1'b0,1'b1,1'b1,32'hDEAD, 1'b0,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[5]  = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[6]  = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0,32'h0,   32'h0,   128'd0, 32'd0};
    vt[7]  = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b1,32'hDEAD, 1'b1,1'b0,1'b1,32'h1230,32'h0,   128'd0, 32'd1};
    vt[8]  = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b1,32'hDEAD, 1'b1,1'b0,1'b1,32'h1230,32'h0,   128'd0, 32'd1};
    vt[9]  = '{1'b1,1'b0,32'h1234,1'b0,1'b1,1'b0,32'h0,    1'b1,1'b0,1'b1,32'h1230,32'h0,   128'd0, 32'd1};
    vt[10] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b1,32'hA0,   1'b1,1'b0,1'b0,32'h1230,32'h0,   128'd0, 32'd1};
    vt[11] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b1,32'hA1,   1'b1,1'b0,1'b0,32'h1230,32'h0,   128'd0, 32'd1};
    vt[12] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b0,32'h0,    1'b1,1'b0,1'b0,32'h1230,32'h0,   128'd0, 32'd1};
    vt[13] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b1,32'hA2,   1'b1,1'b0,1'b0,32'h1230,32'h0,   128'd0, 32'd1};
    vt[14] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b1,32'hA3,   1'b1,1'b0,1'b0,32'h1230,32'h0,   128'd0, 32'd1};
    vt[15] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b0,32'h0,    1'b1,1'b1,1'b0,32'h1230,32'h1230,LINE_A, 32'd1};
    vt[16] = '{1'b1,1'b0,32'h1234,1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0,32'h1230,32'h1230,LINE_A, 32'd1};
    vt[17] = '{1'b0,1'b0,32'h0,   1'b1,1'b0,1'b1,32'hDEAD, 1'b0,1'b0,1'b0,32'h1230,32'h1230,LINE_A, 32'd1};

    // Reset state.
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_stall", {127'd0, o_stall}, 128'd0);
    chk("rst_ie", {127'd0, o_ie}, 128'd0);
    chk("rst_mreq", {127'd0, o_mreq}, 128'd0);
    chk("rst_addrs", {64'd0, o_iaddr, o_maddr}, 128'd0);
    chk("rst_idata", o_idata, 128'd0);
    chk("rst_cnt", {96'd0, o_miss_cnt}, 128'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rd = vt[i].rd; we = vt[i].we; addr = vt[i].addr; rhit = vt[i].rhit;
      mack = vt[i].mack; mvalid = vt[i].mv; mdata = vt[i].mdata;
      #1;
      chk($sformatf("v%0d_stall", i), {127'd0, o_stall}, {127'd0, vt[i].e_stall});
      chk($sformatf("v%0d_ie", i), {127'd0, o_ie}, {127'd0, vt[i].e_ie});
      chk($sformatf("v%0d_mreq", i), {127'd0, o_mreq}, {127'd0, vt[i].e_mreq});
      chk($sformatf("v%0d_maddr", i), {96'd0, o_maddr}, {96'd0, vt[i].e_maddr});
      chk($sformatf("v%0d_iaddr", i), {96'd0, o_iaddr}, {96'd0, vt[i].e_iaddr});
      chk($sformatf("v%0d_idata", i), o_idata, vt[i].e_idata);
      chk($sformatf("v%0d_cnt", i), {96'd0, o_miss_cnt}, {96'd0, vt[i].e_cnt});
    end
    @(negedge clk); idle_inputs();

    // Store held across a refill: penalty 1+1+4+1 stall cycles.
    @(negedge clk); rd = 1'b1; addr = 32'h2008;
    @(negedge clk); rd = 1'b0; rhit = 1'b0; we = 1'b1; addr = 32'h2100;
    mvalid = 1'b1; mdata = 32'h55;
    accepted = 1'b0; prev_ie = 1'b0; overlap = 0; ie_cnt = 0; stall_cyc = 0;
    for (int t = 0; t < 40; t++) begin
      if (t > 0) @(negedge clk);
      #1;
      if (o_ie && !o_stall) overlap++;
      if (o_ie) ie_cnt++;
      if (!o_stall) begin
        accepted = 1'b1;
        break;
      end
      stall_cyc++;
      prev_ie = o_ie;
      mack = o_mreq;
    end
    chk("store_accepted", {127'd0, accepted}, 128'd1);
    chk("store_after_install", {127'd0, prev_ie}, 128'd1);
    chk("store_ie_overlap", overlap, 0);
    chk("store_ie_once", ie_cnt, 1);
    chk("store_stall_cycles", stall_cyc, 7);
    chk("store_cnt", {96'd0, o_miss_cnt}, 128'd2);
    @(negedge clk); idle_inputs();

    // Reset after two of four beats aborts the refill.
    early_we = 0;
    @(negedge clk); rd = 1'b1; addr = 32'h3000;
    @(negedge clk); rhit = 1'b0;
    @(negedge clk); mack = 1'b1;
    #1 if (o_ie) early_we++;
    @(negedge clk); mack = 1'b0; mvalid = 1'b1; mdata = 32'hB0;
    #1 if (o_ie) early_we++;
    @(negedge clk); mdata = 32'hB1;
    #1 if (o_ie) early_we++;
    @(negedge clk); idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("abort_stall", {127'd0, o_stall}, 128'd0);
    chk("abort_ie", {127'd0, o_ie}, 128'd0);
    chk("abort_mreq", {127'd0, o_mreq}, 128'd0);
    chk("abort_addrs", {64'd0, o_iaddr, o_maddr}, 128'd0);
    chk("abort_idata", o_idata, 128'd0);
    chk("abort_cnt", {96'd0, o_miss_cnt}, 128'd0);
    chk("abort_no_ie", early_we, 0);
    @(negedge clk); rst_n = 1'b1;

    // Same line misses again and fetches cleanly; then counter saturation.
    run_miss(32'h3004, 32'hC0);
    chk("cnt_a_1", {96'd0, o_miss_cnt}, 128'd1);
    chk("cnt2_1", {126'd0, s2_miss_cnt}, 128'd1);
    run_miss(32'h4010, 32'hD0);
    chk("cnt_a_2", {96'd0, o_miss_cnt}, 128'd2);
    chk("cnt2_2", {126'd0, s2_miss_cnt}, 128'd2);
    run_miss(32'h5020, 32'hE0);
    chk("cnt_a_3", {96'd0, o_miss_cnt}, 128'd3);
    chk("cnt2_3", {126'd0, s2_miss_cnt}, 128'd3);
    run_miss(32'h6030, 32'hF0);
    chk("cnt_a_4", {96'd0, o_miss_cnt}, 128'd4);
    chk("cnt2_4", {126'd0, s2_miss_cnt}, 128'd3);
    run_miss(32'h704C, 32'h100);
    chk("cnt_a_5", {96'd0, o_miss_cnt}, 128'd5);
    chk("cnt2_5", {126'd0, s2_miss_cnt}, 128'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_cache_refill.md
Name: m_cache_refill

Overview:
Read-miss controller that sits directly upstream of the data cache's install port (write-noallocate, 4-word lines).
- Watches each load's registered hit result.
- On a miss, stalls the CPU, fetches the 128-bit line from main memory as four 32-bit beats, and drives one install cycle into the cache.
- The held load is then replayed and hits.
- Stores never allocate; they are only held off while a refill is in progress.

Parameters:
CNT_WIDTH, 32, width of the saturating miss counter o_miss_cnt

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  reset, asynchronous, active-low
i_rd  input  1  CPU load issued this cycle (held by CPU while o_stall=1)
i_we  input  1  CPU store issued this cycle (held by CPU while o_stall=1)
i_addr  input  `DADDR  CPU load/store address (same address the cache sees)
i_rhit  input  1  cache registered hit flag; valid the cycle after a load
o_stall  output  1  CPU must hold its request
o_ie  output  1  cache install enable
o_iaddr  output  `DADDR  install address, line-aligned (bits 3:0 = 0)
o_idata  output  128  install data, word k in bits [32k+31:32k]
o_mreq  output  1  memory line-read request
o_maddr  output  `DADDR  memory request address, line-aligned
i_mack  input  1  memory accepted request this cycle
i_mvalid  input  1  memory data beat valid
i_mdata  input  32  memory data beat, beats in word order 0..3
o_miss_cnt  output  CNT_WIDTH  number of read misses, saturating

Behaviour:
- Reset (i_rst_n=0, async): state IDLE; o_stall, o_ie, o_mreq = 0; o_iaddr, o_maddr, o_idata, o_miss_cnt, beat counter = 0.
- States: IDLE, LOOKUP, MREQ, FILL, INSTALL.
- IDLE:
  - i_rd=1: latch i_addr into r_addr; go to LOOKUP.
  - i_we alone: stay in IDLE.
- LOOKUP (cycle after the load):
  - i_rhit=1: no action. A new i_rd this cycle is latched and the state stays LOOKUP, so back-to-back hits run without bubbles. Otherwise go to IDLE.
  - i_rhit=0: o_stall=1 combinationally this same cycle; o_miss_cnt += 1 (holds at all-ones); go to MREQ. Any i_rd/i_we presented this cycle is not accepted; the CPU holds it.
- MREQ: o_stall=1, o_mreq=1, o_maddr = {r_addr[hi:4], 4'b0}. Hold until i_mack=1, then go to FILL with beat counter = 0. o_mreq drops the cycle after acceptance.
- FILL: o_stall=1.
  - Each cycle with i_mvalid=1 writes i_mdata into line-buffer word[cnt] and increments cnt (2-bit).
  - Gaps (i_mvalid=0) are allowed and unbounded.
  - The 4th beat (cnt=3) goes to INSTALL.
- INSTALL: exactly one cycle; o_stall=1, o_ie=1, o_iaddr = line address, o_idata = buffer. Next state IDLE.
- The first IDLE cycle after INSTALL has o_stall=0. The held load is re-accepted and its LOOKUP sees i_rhit=1, because the cache's metadata was written at the end of INSTALL.
- Miss penalty: 1 (LOOKUP) + MREQ cycles (≥1) + beat cycles (≥4) + 1 (INSTALL), then the replay.
- i_mvalid outside FILL is ignored; the buffer is unchanged.
- i_mack outside MREQ is ignored.
- Install and store never overlap: o_ie=1 only while o_stall=1, so i_we is not accepted that cycle. The cache forbids simultaneous install and write.
- Reset mid-MREQ/FILL: abort immediately to IDLE, partial line discarded, no o_ie. The memory shares i_rst_n and drops its transaction.
- o_idata/o_iaddr hold their last values outside INSTALL; the cache only samples them when o_ie=1.

Decomposition:
- Shared definitions file: LINE_WORDS=4, line offset width 4, state encodings (3-bit localparams).
- `DADDR/`DADDR_WIDTH come from the existing define file.
- One natural sub-module, m_line_buffer: 4×32 register file with a write strobe and 2-bit word index, presenting the 128-bit concatenation. It has no reset on the data and a clear-on-abort of nothing, since data validity is tracked by the FSM.

Test Plan:
- Hit stream: i_rd at 0x100,0x104,0x108 on consecutive cycles, i_rhit=1 each following cycle -> o_stall stays 0, o_mreq never asserts, o_miss_cnt=0.
- Miss: i_rd 0x1234, i_rhit=0; i_mack after 3 cycles; beats 0xA0,0xA1,0xA2,0xA3 with one idle gap after beat 1 -> o_maddr=0x1230; a single o_ie pulse with o_iaddr=0x1230 and o_idata=0xA3_A2_A1_A0 (word3..word0); o_stall drops the next cycle; replay hits; o_miss_cnt=1.
- Store held: i_we held during a refill -> never accepted while o_stall=1; accepted the first cycle o_stall=0; o_ie and store acceptance never in the same cycle.
- Stray beats: i_mvalid=1 with i_mdata=0xDEAD in IDLE, then a normal miss -> installed line contains only the four FILL beats.
- Reset after 2 of 4 beats -> all outputs 0 within the same cycle; no o_ie ever; a next load at the same line misses again and fetches cleanly.
- CNT_WIDTH=2, five misses -> o_miss_cnt reads 1,2,3,3,3.
